// File: rtl/cpu_pkg.sv
// Shared CPU constants for the memory stage: opcodes, access sizes, LSU state encoding.
// The misalignment helper is consumed only by builds with LSU_MISALIGN_TRAP_EN.
package cpu_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never trap.
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        case (func3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: store strobes/replicated data and load lane
// selection with sign or zero extension. Purely combinational.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = load_word[{addr_lo, 3'b000} +: 8];
    assign half_sel = load_word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data = load_word;
        case (func3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one bus transaction per memory instruction (IDLE/REQ/RESP/DONE).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses and expose MEM_misalign.
// Bus handshake: DM_req is held with stable addr/we/wstrb/wdata until DM_req && DM_gnt;
// exactly one DM_rvalid follows, and it is only honoured while in RESP.
module mem_lsu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        IF_DONE,
    input  logic [4:0]  MEM_op,
    input  logic [2:0]  MEM_func3,
    input  logic [31:0] MEM_aluOut,
    input  logic [31:0] MEM_rs2Data,
    output logic        MEM_DONE,
    output logic [31:0] MEM_ReadData,
    output logic        DM_req,
    input  logic        DM_gnt,
    output logic        DM_we,
    output logic [31:0] DM_addr,
    output logic [3:0]  DM_wstrb,
    output logic [31:0] DM_wdata,
    input  logic        DM_rvalid,
    input  logic [31:0] DM_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        MEM_misalign,
`endif
    output lsu_state_t  state_dbg
);

    lsu_state_t  state;
    logic [2:0]  func3_q;
    logic [1:0]  addr_lo_q;
    logic        is_load_q;

    logic        is_load, is_store, is_mem, trap;
    logic [2:0]  al_func3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_load;

    assign is_load  = (MEM_op == OP_LOAD);
    assign is_store = (MEM_op == OP_STORE);
    assign is_mem   = is_load || is_store;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(MEM_func3, MEM_aluOut[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Store lanes come from the live instruction; load extraction uses the captured access.
    assign al_func3   = (state == IDLE) ? MEM_func3 : func3_q;
    assign al_addr_lo = (state == IDLE) ? MEM_aluOut[1:0] : addr_lo_q;

    lsu_align u_align (
        .func3      (al_func3),
        .addr_lo    (al_addr_lo),
        .store_data (MEM_rs2Data),
        .load_word  (DM_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_data  (al_load)
    );

    assign MEM_DONE  = ((state == IDLE) && !is_mem) || (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            DM_req       <= 1'b0;
            DM_we        <= 1'b0;
            DM_addr      <= 32'h0;
            DM_wstrb     <= 4'h0;
            DM_wdata     <= 32'h0;
            MEM_ReadData <= 32'h0;
            func3_q      <= 3'h0;
            addr_lo_q    <= 2'h0;
            is_load_q    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            MEM_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        func3_q      <= MEM_func3;
                        addr_lo_q    <= MEM_aluOut[1:0];
                        is_load_q    <= is_load;
                        MEM_ReadData <= 32'h0;
                        if (trap) begin
                            state <= DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                            MEM_misalign <= 1'b1;
`endif
                        end else begin
                            state    <= REQ;
                            DM_req   <= 1'b1;
                            DM_we    <= is_store;
                            DM_addr  <= {MEM_aluOut[31:2], 2'b00};
                            DM_wstrb <= is_store ? al_wstrb : 4'b0000;
                            DM_wdata <= is_store ? al_wdata : 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (DM_gnt) begin
                        state  <= RESP;
                        DM_req <= 1'b0;
                    end
                end
                RESP: begin
                    if (DM_rvalid) begin
                        state        <= DONE;
                        MEM_ReadData <= is_load_q ? al_load : 32'h0;
                    end
                end
                DONE: begin
                    if (IF_DONE) begin
                        state        <= IDLE;
                        MEM_ReadData <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
                        MEM_misalign <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: table of single-access vectors plus hand sequences
// for a stalled grant/IF_DONE, mid-transaction reset and (optionally) the misalign trap.
module tb_mem_lsu;
    import cpu_pkg::*;

    localparam logic [4:0] OP_ALU = 5'b01100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        IF_DONE = 1'b1;
    logic [4:0]  MEM_op = OP_ALU;
    logic [2:0]  MEM_func3 = 3'b000;
    logic [31:0] MEM_aluOut = 32'h0;
    logic [31:0] MEM_rs2Data = 32'h0;
    logic        MEM_DONE;
    logic [31:0] MEM_ReadData;
    logic        DM_req;
    logic        DM_gnt = 1'b0;
    logic        DM_we;
    logic [31:0] DM_addr;
    logic [3:0]  DM_wstrb;
    logic [31:0] DM_wdata;
    logic        DM_rvalid = 1'b0;
    logic [31:0] DM_rdata = 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        MEM_misalign;
`endif
    lsu_state_t  state_dbg;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;

    mem_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .IF_DONE      (IF_DONE),
        .MEM_op       (MEM_op),
        .MEM_func3    (MEM_func3),
        .MEM_aluOut   (MEM_aluOut),
        .MEM_rs2Data  (MEM_rs2Data),
        .MEM_DONE     (MEM_DONE),
        .MEM_ReadData (MEM_ReadData),
        .DM_req       (DM_req),
        .DM_gnt       (DM_gnt),
        .DM_we        (DM_we),
        .DM_addr      (DM_addr),
        .DM_wstrb     (DM_wstrb),
        .DM_wdata     (DM_wdata),
        .DM_rvalid    (DM_rvalid),
        .DM_rdata     (DM_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .MEM_misalign (MEM_misalign),
`endif
        .state_dbg    (state_dbg)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    always @(posedge clk) if (DM_req && DM_gnt) req_cnt++;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Driver: one access with grant and response in the earliest cycles.
    task automatic run_vec(input int idx, input vec_t v);
        int base;
        base        = req_cnt;
        MEM_op      = v.op;
        MEM_func3   = v.f3;
        MEM_aluOut  = v.addr;
        MEM_rs2Data = v.rs2;
        IF_DONE     = 1'b1;
        #1;
        chk($sformatf("v%0d done_c0", idx), 32'(MEM_DONE), 32'd0);
        step();
        chk($sformatf("v%0d req_c1", idx), 32'(DM_req), 32'd1);
        chk($sformatf("v%0d addr", idx), DM_addr, v.e_addr);
        chk($sformatf("v%0d we", idx), 32'(DM_we), 32'(v.e_we));
        chk($sformatf("v%0d wstrb", idx), 32'(DM_wstrb), 32'(v.e_wstrb));
        if (v.e_we) chk($sformatf("v%0d wdata", idx), DM_wdata, v.e_wdata);
        DM_gnt = 1'b1;
        step();
        DM_gnt = 1'b0;
        chk($sformatf("v%0d req_c2", idx), 32'(DM_req), 32'd0);
        DM_rvalid = 1'b1;
        DM_rdata  = v.rdata;
        step();
        DM_rvalid = 1'b0;
        chk($sformatf("v%0d done_c3", idx), 32'(MEM_DONE), 32'd1);
        chk($sformatf("v%0d rdata", idx), MEM_ReadData, v.e_rd);
        MEM_op = OP_ALU;
        step();
        chk($sformatf("v%0d idle_state", idx), 32'(state_dbg), 32'(IDLE));
        chk($sformatf("v%0d idle_rdata", idx), MEM_ReadData, 32'h0);
        chk($sformatf("v%0d one_req", idx), 32'(req_cnt - base), 32'd1);
    endtask

    initial begin
        int base;
        vecs[0]  = '{OP_LOAD,  F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{OP_LOAD,  F3_B,  32'h103, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{OP_LOAD,  F3_BU, 32'h103, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00000080};
        vecs[3]  = '{OP_LOAD,  F3_HU, 32'h102, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h000080FF};
        vecs[4]  = '{OP_LOAD,  F3_H,  32'h102, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFF80FF};
        vecs[5]  = '{OP_LOAD,  F3_B,  32'h100, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00000034};
        vecs[6]  = '{OP_LOAD,  F3_H,  32'h100, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h00001234};
        vecs[7]  = '{OP_LOAD,  F3_B,  32'h102, 32'h0,        32'h80FF1234, 1'b0, 32'h100, 4'b0000, 32'h0,        32'hFFFFFFFF};
        vecs[8]  = '{OP_STORE, F3_H,  32'h102, 32'h0000ABCD, 32'h12345678, 1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[9]  = '{OP_STORE, F3_B,  32'h201, 32'h123456A5, 32'h12345678, 1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0};
        vecs[10] = '{OP_STORE, F3_W,  32'h30C, 32'hCAFEF00D, 32'h12345678, 1'b1, 32'h30C, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[11] = '{OP_STORE, F3_B,  32'h003, 32'h00000077, 32'h12345678, 1'b1, 32'h000, 4'b1000, 32'h77777777, 32'h0};

        // Reset values
        #12;
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        chk("rst_req", 32'(DM_req), 32'd0);
        chk("rst_we", 32'(DM_we), 32'd0);
        chk("rst_addr", DM_addr, 32'h0);
        chk("rst_wstrb", 32'(DM_wstrb), 32'd0);
        chk("rst_wdata", DM_wdata, 32'h0);
        chk("rst_rdata", MEM_ReadData, 32'h0);
        rst = 1'b1;
        step();
        chk("nonmem_done", 32'(MEM_DONE), 32'd1);
        step();
        chk("nonmem_no_req", 32'(DM_req), 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Grant held off 4 cycles, then IF_DONE withheld 3 cycles in DONE
        base       = req_cnt;
        MEM_op     = OP_LOAD;
        MEM_func3  = F3_W;
        MEM_aluOut = 32'h404;
        IF_DONE    = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_req%0d", i), 32'(DM_req), 32'd1);
            chk($sformatf("stall_addr%0d", i), DM_addr, 32'h404);
            chk($sformatf("stall_we%0d", i), 32'(DM_we), 32'd0);
            step();
        end
        chk("stall_still_req", 32'(state_dbg), 32'(REQ));
        DM_gnt = 1'b1;
        step();
        DM_gnt = 1'b0;
        chk("stall_resp_req", 32'(DM_req), 32'd0);
        step();
        chk("stall_wait_resp", 32'(state_dbg), 32'(RESP));
        DM_rvalid = 1'b1;
        DM_rdata  = 32'hA5A55A5A;
        step();
        DM_rvalid = 1'b0;
        DM_rdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_done%0d", i), 32'(MEM_DONE), 32'd1);
            chk($sformatf("hold_data%0d", i), MEM_ReadData, 32'hA5A55A5A);
            chk($sformatf("hold_state%0d", i), 32'(state_dbg), 32'(DONE));
            step();
        end
        IF_DONE = 1'b1;
        MEM_op  = OP_ALU;
        step();
        chk("stall_idle", 32'(state_dbg), 32'(IDLE));
        chk("stall_one_req", 32'(req_cnt - base), 32'd1);

        // Reset during RESP, then a stray response
        base       = req_cnt;
        MEM_op     = OP_LOAD;
        MEM_func3  = F3_W;
        MEM_aluOut = 32'h500;
        step();
        DM_gnt = 1'b1;
        step();
        DM_gnt = 1'b0;
        chk("mid_in_resp", 32'(state_dbg), 32'(RESP));
        rst    = 1'b0;
        MEM_op = OP_ALU;
        #1;
        chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        chk("mid_rst_req", 32'(DM_req), 32'd0);
        chk("mid_rst_addr", DM_addr, 32'h0);
        #2;
        rst = 1'b1;
        step();
        DM_rvalid = 1'b1;
        DM_rdata  = 32'h12345678;
        step();
        DM_rvalid = 1'b0;
        chk("stray_state", 32'(state_dbg), 32'(IDLE));
        chk("stray_rdata", MEM_ReadData, 32'h0);
        chk("stray_done", 32'(MEM_DONE), 32'd1);
        step();
        chk("stray_no_retry", 32'(DM_req), 32'd0);
        chk("mid_one_req", 32'(req_cnt - base), 32'd1);

`ifdef LSU_MISALIGN_TRAP_EN
        base       = req_cnt;
        MEM_op     = OP_LOAD;
        MEM_func3  = F3_W;
        MEM_aluOut = 32'h101;
        #1;
        chk("trap_done_c0", 32'(MEM_DONE), 32'd0);
        step();
        chk("trap_state", 32'(state_dbg), 32'(DONE));
        chk("trap_flag", 32'(MEM_misalign), 32'd1);
        chk("trap_no_req", 32'(DM_req), 32'd0);
        chk("trap_done", 32'(MEM_DONE), 32'd1);
        chk("trap_rdata", MEM_ReadData, 32'h0);
        MEM_op = OP_ALU;
        step();
        chk("trap_idle", 32'(state_dbg), 32'(IDLE));
        chk("trap_flag_clr", 32'(MEM_misalign), 32'd0);
        chk("trap_req_cnt", 32'(req_cnt - base), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
